// File: rtl/fairy_mem_stage.sv
//==============================================================================
// Module   : fairy_mem_stage
// Purpose  : Memory pipeline stage. Issues MIPS load/store requests over a
//            req/addr_ok/data_ok handshake, aligns load data, retires results.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fairy_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       pc_i,
  input  logic [63:0]       data_i,
  input  logic [31:0]       op1_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [1:0]        hilo_we_i,
  input  logic              exception_i,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_addr_ok,
  input  logic              dmem_data_ok,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wb_reg_waddr_o,
  output logic              wb_reg_we_o,
  output logic [63:0]       hilo_data_o,
  output logic [1:0]        hilo_we_o,
  output logic [31:0]       pc_o,
  output logic              addr_err_o
);

  localparam logic [5:0] c_op_lb  = 6'b100000;
  localparam logic [5:0] c_op_lbu = 6'b100100;
  localparam logic [5:0] c_op_lh  = 6'b100001;
  localparam logic [5:0] c_op_lhu = 6'b100101;
  localparam logic [5:0] c_op_lw  = 6'b100011;
  localparam logic [5:0] c_op_lwl = 6'b100010;
  localparam logic [5:0] c_op_lwr = 6'b100110;
  localparam logic [5:0] c_op_sb  = 6'b101000;
  localparam logic [5:0] c_op_sh  = 6'b101001;
  localparam logic [5:0] c_op_sw  = 6'b101011;
  localparam logic [5:0] c_op_swl = 6'b101010;
  localparam logic [5:0] c_op_swr = 6'b101110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_op;
  logic [31:0] r_pc, r_op1;
  logic [63:0] r_data;
  logic [4:0]  r_waddr;
  logic        r_we;
  logic [1:0]  r_hilo_we;
  logic        r_flush;

  logic        r_wb_valid, r_wb_we, r_addr_err;
  logic [31:0] r_wb_data, r_pc_o;
  logic [4:0]  r_wb_waddr;
  logic [63:0] r_hilo_data;
  logic [1:0]  r_hilo_we_o;

  logic        w_accept, w_in_mem, w_in_misal;
  logic        w_retire_alu, w_retire_mem, w_set_flush, w_clr_flush;
  logic        w_is_store;
  logic [1:0]  w_a;
  logic [4:0]  w_shl, w_shr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load_data, w_lane;

  assign ready_o  = reset_n & (r_state == S_IDLE);
  assign w_accept = valid_i & ready_o & ~exception_i;

  // Incoming decode: is this a memory op, and would it fault on alignment?
  always_comb begin
    w_in_mem   = 1'b0;
    w_in_misal = 1'b0;
    case (inst_i[31:26])
      c_op_lb, c_op_lbu, c_op_lwl, c_op_lwr, c_op_sb, c_op_swl, c_op_swr:
        w_in_mem = 1'b1;
      c_op_lh, c_op_lhu, c_op_sh: begin
        w_in_mem   = 1'b1;
        w_in_misal = data_i[0];
      end
      c_op_lw, c_op_sw: begin
        w_in_mem   = 1'b1;
        w_in_misal = |data_i[1:0];
      end
      default: ;
    endcase
  end

  assign w_a   = r_data[1:0];
  assign w_shl = {w_a, 3'b000};
  assign w_shr = {~w_a, 3'b000};
  assign w_is_store = (r_op == c_op_sb) || (r_op == c_op_sh) || (r_op == c_op_sw) ||
                      (r_op == c_op_swl) || (r_op == c_op_swr);

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    case (r_op)
      c_op_sb: begin
        w_wstrb = 4'b0001 << w_a;
        w_wdata = {4{r_op1[7:0]}};
      end
      c_op_sh: begin
        w_wstrb = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_op1[15:0]}};
      end
      c_op_sw: begin
        w_wstrb = 4'b1111;
        w_wdata = r_op1;
      end
      c_op_swl: begin
        w_wstrb = 4'b1111 >> (~w_a);
        w_wdata = r_op1 >> w_shr;
      end
      c_op_swr: begin
        w_wstrb = 4'b1111 << w_a;
        w_wdata = r_op1 << w_shl;
      end
      default: ;
    endcase
  end

  assign w_lane = dmem_rdata >> w_shl;

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_op)
      c_op_lb:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      c_op_lbu: w_load_data = {24'h0, w_lane[7:0]};
      c_op_lh:  w_load_data = w_a[1] ? {{16{dmem_rdata[31]}}, dmem_rdata[31:16]}
                                     : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      c_op_lhu: w_load_data = w_a[1] ? {16'h0, dmem_rdata[31:16]}
                                     : {16'h0, dmem_rdata[15:0]};
      c_op_lwl: begin
        case (w_a)
          2'd0:    w_load_data = {dmem_rdata[7:0], r_op1[23:0]};
          2'd1:    w_load_data = {dmem_rdata[15:0], r_op1[15:0]};
          2'd2:    w_load_data = {dmem_rdata[23:0], r_op1[7:0]};
          default: w_load_data = dmem_rdata;
        endcase
      end
      c_op_lwr: begin
        case (w_a)
          2'd0:    w_load_data = dmem_rdata;
          2'd1:    w_load_data = {r_op1[31:24], dmem_rdata[31:8]};
          2'd2:    w_load_data = {r_op1[31:16], dmem_rdata[31:16]};
          default: w_load_data = {r_op1[31:8], dmem_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // A flushed request still completes its handshake; the response is drained.
  always_comb begin
    w_state_next = r_state;
    w_retire_alu = 1'b0;
    w_retire_mem = 1'b0;
    w_set_flush  = 1'b0;
    w_clr_flush  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_mem && !w_in_misal) w_state_next = S_REQ;
          else                         w_retire_alu = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem_addr_ok) begin
          w_state_next = (r_flush || exception_i) ? S_DRAIN : S_WAIT;
          w_clr_flush  = 1'b1;
        end else if (exception_i) begin
          w_set_flush = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_data_ok) begin
          w_state_next = S_IDLE;
          w_retire_mem = ~exception_i;
        end else if (exception_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dmem_data_ok) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= 6'h0;
      r_pc        <= 32'h0;
      r_op1       <= 32'h0;
      r_data      <= 64'h0;
      r_waddr     <= 5'h0;
      r_we        <= 1'b0;
      r_hilo_we   <= 2'b00;
      r_flush     <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_addr_err  <= 1'b0;
      r_wb_data   <= 32'h0;
      r_pc_o      <= 32'h0;
      r_wb_waddr  <= 5'h0;
      r_hilo_data <= 64'h0;
      r_hilo_we_o <= 2'b00;
    end else begin
      if (w_accept) begin
        r_op      <= inst_i[31:26];
        r_pc      <= pc_i;
        r_op1     <= op1_i;
        r_data    <= data_i;
        r_waddr   <= reg_waddr_i;
        r_we      <= reg_we_i;
        r_hilo_we <= hilo_we_i;
      end
      if (w_set_flush)      r_flush <= 1'b1;
      else if (w_clr_flush) r_flush <= 1'b0;

      r_wb_valid <= w_retire_alu | w_retire_mem;
      r_addr_err <= w_retire_alu & w_in_misal;
      if (w_retire_alu) begin
        r_wb_data   <= data_i[31:0];
        r_wb_waddr  <= reg_waddr_i;
        r_wb_we     <= reg_we_i & ~w_in_misal;
        r_hilo_data <= data_i;
        r_hilo_we_o <= hilo_we_i;
        r_pc_o      <= pc_i;
      end else if (w_retire_mem) begin
        r_wb_data   <= w_load_data;
        r_wb_waddr  <= r_waddr;
        r_wb_we     <= r_we & ~w_is_store;
        r_hilo_data <= r_data;
        r_hilo_we_o <= r_hilo_we;
        r_pc_o      <= r_pc;
      end
    end
  end

  assign dmem_req       = (r_state == S_REQ);
  assign dmem_wr        = w_is_store;
  assign dmem_addr      = {r_data[ADDR_W-1:2], 2'b00};
  assign dmem_wstrb     = w_wstrb;
  assign dmem_wdata     = w_wdata;
  assign wb_valid_o     = r_wb_valid;
  assign wb_data_o      = r_wb_data;
  assign wb_reg_waddr_o = r_wb_waddr;
  assign wb_reg_we_o    = r_wb_we;
  assign hilo_data_o    = r_hilo_data;
  assign hilo_we_o      = r_hilo_we_o;
  assign pc_o           = r_pc_o;
  assign addr_err_o     = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_fairy_mem_stage.sv
//==============================================================================
// Module   : tb_fairy_mem_stage
// Purpose  : Directed self-checking bench for fairy_mem_stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fairy_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i, ready_o;
  logic [31:0] inst_i, pc_i, op1_i;
  logic [63:0] data_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [1:0]  hilo_we_i;
  logic        exception_i;
  logic        dmem_req, dmem_wr;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_addr_ok, dmem_data_ok;
  logic [31:0] dmem_rdata;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_reg_waddr_o;
  logic        wb_reg_we_o;
  logic [63:0] hilo_data_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] pc_o;
  logic        addr_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  fairy_mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .data_i(data_i), .op1_i(op1_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .hilo_we_i(hilo_we_i),
    .exception_i(exception_i), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_addr_ok(dmem_addr_ok), .dmem_data_ok(dmem_data_ok),
    .dmem_rdata(dmem_rdata), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_we_o(wb_reg_we_o),
    .hilo_data_o(hilo_data_o), .hilo_we_o(hilo_we_o), .pc_o(pc_o),
    .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one instruction for a single cycle; stage is assumed idle.
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] rt, input logic we);
    valid_i     = 1'b1;
    inst_i      = inst;
    data_i      = {32'h0, addr};
    op1_i       = rt;
    reg_we_i    = we;
    reg_waddr_i = 5'd9;
    pc_i        = 32'hBFC0_0100;
    tick();
    valid_i = 1'b0;
  endtask

  // Memory responder: addr_ok after ad cycles, data_ok dd cycles later.
  task automatic handshake(input logic [31:0] rdata, input int ad, input int dd);
    repeat (ad) tick();
    dmem_addr_ok = 1'b1;
    tick();
    dmem_addr_ok = 1'b0;
    repeat (dd) tick();
    dmem_rdata   = rdata;
    dmem_data_ok = 1'b1;
    tick();
    dmem_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; valid_i = 1'b0; inst_i = '0; pc_i = '0; data_i = '0;
    op1_i = '0; reg_waddr_i = '0; reg_we_i = 1'b0; hilo_we_i = 2'b00;
    exception_i = 1'b0; dmem_addr_ok = 1'b0; dmem_data_ok = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_ready", ready_o, 0);
    check("rst_req", dmem_req, 0);
    check("rst_wbvalid", wb_valid_o, 0);
    check("rst_wbdata", wb_data_o, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", ready_o, 1);

    // ALU op retires next cycle
    valid_i = 1'b1; inst_i = 32'h0000_0020; data_i = 64'hAAAA_0001_1234_5678;
    reg_we_i = 1'b1; reg_waddr_i = 5'd5; hilo_we_i = 2'b10; pc_i = 32'h0000_0040;
    tick();
    valid_i = 1'b0;
    check("alu_valid", wb_valid_o, 1);
    check("alu_data", wb_data_o, 32'h1234_5678);
    check("alu_waddr", wb_reg_waddr_o, 5);
    check("alu_we", wb_reg_we_o, 1);
    check("alu_hilo", hilo_data_o, 64'hAAAA_0001_1234_5678);
    check("alu_hilowe", hilo_we_o, 2'b10);
    check("alu_pc", pc_o, 32'h0000_0040);
    check("alu_noreq", dmem_req, 0);
    tick();
    check("alu_pulse", wb_valid_o, 0);
    hilo_we_i = 2'b00;

    // LB 0x103, addr_ok two cycles late, data_ok three cycles after
    issue(32'h8000_0000, 32'h0000_0103, 32'h0, 1'b1);
    check("lb_req", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h0000_0100);
    check("lb_wr", dmem_wr, 0);
    check("lb_ready0", ready_o, 0);
    tick();
    check("lb_req_hold1", dmem_req, 1);
    tick();
    check("lb_req_hold2", dmem_req, 1);
    check("lb_ready1", ready_o, 0);
    dmem_addr_ok = 1'b1;
    tick();
    dmem_addr_ok = 1'b0;
    check("lb_req_drop", dmem_req, 0);
    check("lb_ready_wait", ready_o, 0);
    tick(); tick();
    check("lb_no_early_wb", wb_valid_o, 0);
    dmem_rdata = 32'h80AA_BBCC; dmem_data_ok = 1'b1;
    tick();
    dmem_data_ok = 1'b0;
    check("lb_valid", wb_valid_o, 1);
    check("lb_data", wb_data_o, 32'hFFFF_FF80);
    check("lb_waddr", wb_reg_waddr_o, 9);
    check("lb_ready_end", ready_o, 1);

    // SH 0x202
    issue(32'hA400_0000, 32'h0000_0202, 32'h0000_BEEF, 1'b1);
    check("sh_wr", dmem_wr, 1);
    check("sh_addr", dmem_addr, 32'h0000_0200);
    check("sh_wstrb", dmem_wstrb, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    handshake(32'h0, 0, 1);
    check("sh_valid", wb_valid_o, 1);
    check("sh_we", wb_reg_we_o, 0);

    // SB 0x301
    issue(32'hA000_0000, 32'h0000_0301, 32'h1234_56A5, 1'b0);
    check("sb_wstrb", dmem_wstrb, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    handshake(32'h0, 1, 0);

    // SWL 0x1 and SWR 0x2
    issue(32'hA800_0000, 32'h0000_0001, 32'h1122_3344, 1'b0);
    check("swl_wstrb", dmem_wstrb, 4'b0011);
    check("swl_wdata", dmem_wdata, 32'h0000_1122);
    handshake(32'h0, 0, 0);
    issue(32'hB800_0000, 32'h0000_0002, 32'h1122_3344, 1'b0);
    check("swr_wstrb", dmem_wstrb, 4'b1100);
    check("swr_wdata", dmem_wdata, 32'h3344_0000);
    handshake(32'h0, 0, 0);

    // LWL 0x1 / LWR 0x2
    issue(32'h8800_0000, 32'h0000_0001, 32'h1122_3344, 1'b1);
    handshake(32'hAABB_CCDD, 0, 0);
    check("lwl_valid", wb_valid_o, 1);
    check("lwl_data", wb_data_o, 32'hCCDD_3344);
    issue(32'h9800_0000, 32'h0000_0002, 32'h1122_3344, 1'b1);
    handshake(32'hAABB_CCDD, 0, 0);
    check("lwr_data", wb_data_o, 32'h1122_AABB);

    // LH / LHU upper halfword
    issue(32'h8400_0000, 32'h0000_0012, 32'h0, 1'b1);
    handshake(32'h8001_7FFF, 0, 0);
    check("lh_data", wb_data_o, 32'hFFFF_8001);
    issue(32'h9400_0000, 32'h0000_0012, 32'h0, 1'b1);
    handshake(32'h8001_7FFF, 0, 0);
    check("lhu_data", wb_data_o, 32'h0000_8001);

    // Misaligned LW 0x6
    issue(32'h8C00_0000, 32'h0000_0006, 32'h0, 1'b1);
    check("lw_mis_noreq", dmem_req, 0);
    check("lw_mis_valid", wb_valid_o, 1);
    check("lw_mis_err", addr_err_o, 1);
    check("lw_mis_we", wb_reg_we_o, 0);
    check("lw_mis_ready", ready_o, 1);
    tick();
    check("lw_mis_pulse", wb_valid_o, 0);
    check("lw_mis_err_pulse", addr_err_o, 0);

    // Flush while in WAIT
    issue(32'h8C00_0000, 32'h0000_0010, 32'h0, 1'b1);
    dmem_addr_ok = 1'b1;
    tick();
    dmem_addr_ok = 1'b0;
    exception_i = 1'b1;
    tick();
    exception_i = 1'b0;
    check("fw_ready", ready_o, 0);
    check("fw_req", dmem_req, 0);
    tick();
    dmem_rdata = 32'hDEAD_BEEF; dmem_data_ok = 1'b1;
    tick();
    dmem_data_ok = 1'b0;
    check("fw_no_wb", wb_valid_o, 0);
    check("fw_ready_back", ready_o, 1);

    // Flush while in REQ: handshake still completes
    issue(32'h8C00_0000, 32'h0000_0020, 32'h0, 1'b1);
    exception_i = 1'b1;
    tick();
    exception_i = 1'b0;
    check("fr_req_hold1", dmem_req, 1);
    tick();
    check("fr_req_hold2", dmem_req, 1);
    dmem_addr_ok = 1'b1;
    tick();
    dmem_addr_ok = 1'b0;
    check("fr_req_drop", dmem_req, 0);
    check("fr_ready", ready_o, 0);
    dmem_data_ok = 1'b1;
    tick();
    dmem_data_ok = 1'b0;
    check("fr_no_wb", wb_valid_o, 0);
    check("fr_ready_back", ready_o, 1);

    // Reset asserted mid-request drops req asynchronously
    issue(32'h8C00_0000, 32'h0000_0030, 32'h0, 1'b1);
    check("rm_req", dmem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_req_async", dmem_req, 0);
    check("rm_ready", ready_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rm_ready_back", ready_o, 1);
    check("rm_no_req", dmem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
